id_ex_operand_stage: RTL

- Pipeline register between instruction decode and the ALU.
- Captures decoded operands and control, then applies EX/MEM and MEM/WB forwarding.
- Selects immediate or shift-amount operands and drives the ALU's src1, src2 and 4-bit control inputs.
- Detects load-use hazards and inserts bubbles; handles flush from branch resolution.

---
 rtl/id_ex_operand_stage_pkg.sv | 49 ++++
 rtl/id_ex_operand_stage_fwd_mux.sv | 39 +++
 rtl/id_ex_operand_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, ALU control codes, forwarding selects and the ID/EX control payload.
package id_ex_operand_stage_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FWD_W   = 2;

  typedef enum logic [CTRL_W-1:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SLTI = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SUB  = 4'd6,
    ALU_BEQ  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SRAV = 4'd9,
    ALU_BNE  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_ctrl_e;

  typedef enum logic [FWD_W-1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Single-bit control carried through the ID/EX register
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic sign_ext;
    logic shamt_src;
  } ex_ctrl_t;

  // Widen a 16-bit immediate to the datapath width
  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                 input logic             sign_ext);
    logic [DATA_W-IMM_W-1:0] upper;
    upper = sign_ext ? {(DATA_W-IMM_W){imm[IMM_W-1]}} : '0;
    return {upper, imm};
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding comparator and mux; EX/MEM beats MEM/WB, r0 never forwards.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [RADDR_W-1:0] src_addr_i,
  input  logic [DATA_W-1:0]  reg_data_i,
  input  logic               exmem_reg_write_i,
  input  logic [RADDR_W-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0]  exmem_result_i,
  input  logic               memwb_reg_write_i,
  input  logic [RADDR_W-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0]  memwb_data_i,
  output logic [DATA_W-1:0]  data_c,
  output logic [FWD_W-1:0]   sel_c
);

  logic exmem_hit;
  logic memwb_hit;

  // Address match against each producer, excluding the hardwired zero register
  always_comb begin
    exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr_i);
    memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_addr_i);
  end

  // Youngest producer wins
  always_comb begin
    data_c = reg_data_i;
    sel_c  = FWD_REG;
    if (exmem_hit) begin
      data_c = exmem_result_i;
      sel_c  = FWD_EXMEM;
    end else if (memwb_hit) begin
      data_c = memwb_data_i;
      sel_c  = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall, flush, forwarding and ALU operand select.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [RADDR_W-1:0] id_rs_addr_i,
  input  logic [RADDR_W-1:0] id_rt_addr_i,
  input  logic [RADDR_W-1:0] id_rd_addr_i,
  input  logic [DATA_W-1:0]  id_rs_data_i,
  input  logic [DATA_W-1:0]  id_rt_data_i,
  input  logic [IMM_W-1:0]   id_imm_i,
  input  logic [CTRL_W-1:0]  id_alu_ctrl_i,
  input  logic               id_alu_src_i,
  input  logic               id_sign_ext_i,
  input  logic               id_shamt_src_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               id_mem_write_i,
  input  logic               exmem_reg_write_i,
  input  logic [RADDR_W-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0]  exmem_result_i,
  input  logic               memwb_reg_write_i,
  input  logic [RADDR_W-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0]  memwb_data_i,
  output logic               load_use_stall_o,
  output logic               ex_valid_o,
  output logic [DATA_W-1:0]  ex_src1_o,
  output logic [DATA_W-1:0]  ex_src2_o,
  output logic [CTRL_W-1:0]  ex_alu_ctrl_o,
  output logic [DATA_W-1:0]  ex_store_data_o,
  output logic [RADDR_W-1:0] ex_rd_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic [FWD_W-1:0]   ex_fwd_a_o,
  output logic [FWD_W-1:0]   ex_fwd_b_o
);

  ex_ctrl_t           ctrl_q,     ctrl_d;
  logic [CTRL_W-1:0]  alu_ctrl_q, alu_ctrl_d;
  logic [RADDR_W-1:0] rs_addr_q,  rs_addr_d;
  logic [RADDR_W-1:0] rt_addr_q,  rt_addr_d;
  logic [RADDR_W-1:0] rd_q,       rd_d;
  logic [DATA_W-1:0]  rs_data_q,  rs_data_d;
  logic [DATA_W-1:0]  rt_data_q,  rt_data_d;
  logic [IMM_W-1:0]   imm_q,      imm_d;

  logic               stall_c;
  logic [DATA_W-1:0]  fwd_a_data_c;
  logic [DATA_W-1:0]  fwd_b_data_c;
  logic [FWD_W-1:0]   fwd_a_sel_c;
  logic [FWD_W-1:0]   fwd_b_sel_c;

  // Load in EX whose destination is consumed by the instruction in ID
  always_comb begin
    stall_c = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && id_valid_i &&
              ((rd_q == id_rs_addr_i) ||
               ((rd_q == id_rt_addr_i) && (!id_alu_src_i || id_mem_write_i)));
  end

  // Next ID/EX contents: bubble on flush, stall or empty ID, else capture with WB bypass
  always_comb begin
    ctrl_d     = '0;
    alu_ctrl_d = '0;
    rs_addr_d  = '0;
    rt_addr_d  = '0;
    rd_d       = '0;
    rs_data_d  = '0;
    rt_data_d  = '0;
    imm_d      = '0;
    if (!flush_i && !stall_c && id_valid_i) begin
      ctrl_d.valid     = 1'b1;
      ctrl_d.reg_write = id_reg_write_i;
      ctrl_d.mem_read  = id_mem_read_i;
      ctrl_d.mem_write = id_mem_write_i;
      ctrl_d.alu_src   = id_alu_src_i;
      ctrl_d.sign_ext  = id_sign_ext_i;
      ctrl_d.shamt_src = id_shamt_src_i;
      alu_ctrl_d       = id_alu_ctrl_i;
      rs_addr_d        = id_rs_addr_i;
      rt_addr_d        = id_rt_addr_i;
      rd_d             = id_rd_addr_i;
      imm_d            = id_imm_i;
      rs_data_d        = id_rs_data_i;
      rt_data_d        = id_rt_data_i;
      if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rs_addr_i)) begin
        rs_data_d = memwb_data_i;
      end
      if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rt_addr_i)) begin
        rt_data_d = memwb_data_i;
      end
    end
  end

  // ID/EX register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      alu_ctrl_q <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_ctrl_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rd_q       <= rd_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
    end
  end

  id_ex_operand_stage_fwd_mux u_fwd_a (
    .src_addr_i        (rs_addr_q),
    .reg_data_i        (rs_data_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .data_c            (fwd_a_data_c),
    .sel_c             (fwd_a_sel_c)
  );

  id_ex_operand_stage_fwd_mux u_fwd_b (
    .src_addr_i        (rt_addr_q),
    .reg_data_i        (rt_data_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .data_c            (fwd_b_data_c),
    .sel_c             (fwd_b_sel_c)
  );

  // ALU operand selection; the ALU pulls the shift amount from src1[10:6]
  always_comb begin
    ex_src1_o       = ctrl_q.shamt_src ? ext_imm(imm_q, 1'b0) : fwd_a_data_c;
    ex_src2_o       = ctrl_q.alu_src ? ext_imm(imm_q, ctrl_q.sign_ext) : fwd_b_data_c;
    ex_store_data_o = fwd_b_data_c;
    ex_fwd_a_o      = fwd_a_sel_c;
    ex_fwd_b_o      = fwd_b_sel_c;
  end

  // Registered control straight to the EX stage
  always_comb begin
    load_use_stall_o = stall_c;
    ex_valid_o       = ctrl_q.valid;
    ex_alu_ctrl_o    = alu_ctrl_q;
    ex_rd_o          = rd_q;
    ex_reg_write_o   = ctrl_q.reg_write;
    ex_mem_read_o    = ctrl_q.mem_read;
    ex_mem_write_o   = ctrl_q.mem_write;
  end

endmodule
